bcd2bin_seq: RTL and testbench

//  - Sequential packed-BCD to binary converter. It is the reverse path of the
//    4-bit binary to 8-bit BCD converter.
//  - Accepts DIGITS BCD digits and produces their unsigned binary value.
//  - Processes one digit per clock, most significant digit first.
//  - Uses a valid/ready handshake on both sides. Sits between a BCD entry

---
 rtl/bcd2bin_seq.sv | 133 +++++++++++++
 tb/tb_bcd2bin_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, one digit per clock, MSD first.
// Optional macro BCD2BIN_ERR_CHECK_EN enables per-digit (>9) error flagging.
module bcd2bin_seq #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int unsigned IN_W  = 4 * DIGITS;
    localparam int unsigned CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [IN_W-1:0]   sr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIN_W-1:0]  acc_q;
    logic [3:0]        digit;
    logic [BIN_W-1:0]  acc_step;
    logic              last_digit;
    logic              accept;
    logic              conv_en;
    logic              retire;

    assign digit      = sr_q[IN_W-1 -: 4];
    assign acc_step   = acc_q * BIN_W'(10) + BIN_W'(digit);
    assign last_digit = (cnt_q == CNT_W'(DIGITS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid) state_d = S_CONV;
            S_CONV: if (last_digit) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = in_valid ? S_CONV : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and datapath controls; a retiring DONE may accept in the same edge
    always_comb begin
        in_ready = 1'b0;
        conv_en  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_CONV: conv_en  = 1'b1;
            S_DONE: begin
                in_ready = out_ready;
                retire   = out_ready;
            end
            default: ;
        endcase
        accept = in_valid & in_ready;
    end

    // Accumulator, digit shifter and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            bin_out   <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                sr_q  <= bcd_in;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (conv_en) begin
                sr_q  <= sr_q << 4;
                acc_q <= acc_step;
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (conv_en && last_digit) begin
                out_valid <= 1'b1;
                bin_out   <= acc_step;
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef BCD2BIN_ERR_CHECK_EN
    logic err_acc_q;
    logic digit_bad;

    assign digit_bad = (digit > 4'd9);

    // Sticky invalid-digit flag, cleared on every accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_acc_q <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (accept) begin
                err_acc_q <= 1'b0;
            end else if (conv_en) begin
                err_acc_q <= err_acc_q | digit_bad;
            end
            if (conv_en && last_digit) begin
                err <= err_acc_q | digit_bad;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed table, corner sequences, random vs model.
module tb_bcd2bin_seq;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned BIN_W  = 7;
`ifdef BCD2BIN_ERR_CHECK_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [4*DIGITS-1:0]  bcd_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [BIN_W-1:0]     bin_out;
    logic                 err;

    int n_cmp = 0;
    int n_bad = 0;

    bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*DIGITS-1:0] bcd;
        int                  bin;
        bit                  err;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Positional decimal value of the digits, reduced to the output width
    function automatic int ref_bin(input logic [4*DIGITS-1:0] b);
        int v = 0;
        int p = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            v += int'(b[4*i +: 4]) * p;
            p *= 10;
        end
        return v % (1 << BIN_W);
    endfunction

    function automatic bit ref_err(input logic [4*DIGITS-1:0] b);
        bit e = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++)
            if (b[4*i +: 4] > 4'd9) e = 1'b1;
        return ERR_ON && e;
    endfunction

    // One transaction from IDLE; out_ready held low for 'stall' cycles once the result shows
    task automatic convert(input logic [4*DIGITS-1:0] b, input int exp_b, input bit exp_e,
                           input int stall, input string name);
        int n;
        chk({name, " in_ready"}, int'(in_ready), 1);
        in_valid  = 1'b1;
        bcd_in    = b;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, " latency"}, n, int'(DIGITS));
        chk({name, " bin_out"}, int'(bin_out), exp_b);
        chk({name, " err"}, int'(err), int'(exp_e));
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({name, " held"}, int'(out_valid) * 1000 + int'(bin_out), 1000 + exp_b);
        end
        out_ready = 1'b1;
        tick();
        chk({name, " retired"}, int'(out_valid), 0);
    endtask

    vec_t tbl [6];

    initial begin
        int n;
        logic [4*DIGITS-1:0] rb;

        tbl[0] = '{8'h42, 42, 1'b0};
        tbl[1] = '{8'h99, 99, 1'b0};
        tbl[2] = '{8'h00, 0,  1'b0};
        tbl[3] = '{8'h09, 9,  1'b0};
        tbl[4] = '{8'h3A, 40, ERR_ON};
        tbl[5] = '{8'h12, 12, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        bcd_in    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset bin_out", int'(bin_out), 0);
        chk("reset err", int'(err), 0);
        chk("reset in_ready", int'(in_ready), 1);

        for (int i = 0; i < 6; i++)
            convert(tbl[i].bcd, tbl[i].bin, tbl[i].err, 0, $sformatf("tbl%0d", i));

        // Backpressure: result held while downstream stalls
        in_valid  = 1'b1;
        bcd_in    = 8'h57;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp latency", n, int'(DIGITS));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp out_valid", int'(out_valid), 1);
            chk("bp bin_out", int'(bin_out), 57);
            chk("bp in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp in_ready released", int'(in_ready), 1);
        tick();
        chk("bp idle out_valid", int'(out_valid), 0);
        chk("bp bin_out kept", int'(bin_out), 57);

        // Back-to-back: second accept on the retiring edge
        in_valid  = 1'b1;
        bcd_in    = 8'h15;
        out_ready = 1'b1;
        tick();
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("b2b first latency", n, int'(DIGITS));
        chk("b2b first bin", int'(bin_out), 15);
        bcd_in = 8'h86;
        #1;
        chk("b2b in_ready in DONE", int'(in_ready), 1);
        tick();
        chk("b2b retire", int'(out_valid), 0);
        chk("b2b no reaccept", int'(in_ready), 0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("b2b second latency", n, int'(DIGITS));
        chk("b2b second bin", int'(bin_out), 86);
        tick();
        chk("b2b idle", int'(out_valid), 0);

        // Reset mid-conversion discards the partial result
        in_valid = 1'b1;
        bcd_in   = 8'h77;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rst mid-conv out_valid", int'(out_valid), 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst2 out_valid", int'(out_valid), 0);
        chk("rst2 bin_out", int'(bin_out), 0);
        chk("rst2 err", int'(err), 0);
        chk("rst2 in_ready", int'(in_ready), 1);
        tick();
        chk("rst2 stays idle", int'(out_valid), 0);
        convert(8'h23, 23, 1'b0, 0, "after rst");

        for (int i = 0; i < 40; i++) begin
            rb = (4*DIGITS)'($urandom);
            convert(rb, ref_bin(rb), ref_err(rb), int'($urandom_range(0, 3)),
                    $sformatf("rand%0d h%0h", i, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
